inc_pulse_arbiter: RTL

Round-robin scheduler that shares one downstream update port between up to `N_REQ` increment-pulse sources. Each source is the 1-cycle `IncPulse_out` of a debounced push-button channel, covering both single pulses and continuous-press pulse trains. The block counts pending pulses per source so that bursts are not lost. It then offers them one at a time to a single shared counter/update unit over a valid/ready handshake. It sits between the button front-end instances and the shared counter datapath.

---
 rtl/inc_pulse_arbiter.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/inc_pulse_arbiter.sv
// inc_pulse_arbiter
// Shares one downstream update port between N_REQ increment-pulse sources.
// Each source has a saturating pending counter, so pulse bursts are queued
// rather than lost. A round-robin two-state FSM offers one pending channel at
// a time over a valid/ready handshake. A bubble cycle always follows each
// accepted grant.
module inc_pulse_arbiter #(
    parameter int  N_REQ  = 4,
    parameter int  PEND_W = 3,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic [N_REQ-1:0]  IncPulse_in,
    input  logic              Grant_ready,
    input  logic              Clear_overflow,
    output logic              Grant_valid,
    output logic [ID_W-1:0]   Grant_id,
    output logic [N_REQ-1:0]  Overflow_sticky,
    output logic              Pending_any
);

    localparam logic [0:0]        ST_IDLE  = 1'b0;
    localparam logic [0:0]        ST_OFFER = 1'b1;
    localparam logic [PEND_W-1:0] CNT_MAX  = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] CNT_ONE  = PEND_W'(1);
    localparam logic [PEND_W-1:0] CNT_ZERO = PEND_W'(0);
    localparam logic [ID_W-1:0]   LAST_RST = ID_W'(N_REQ - 1);

    logic [PEND_W-1:0] cnt_r      [N_REQ];
    logic [PEND_W-1:0] cnt_nxt_s  [N_REQ];
    logic [N_REQ-1:0]  dec_s;
    logic [N_REQ-1:0]  ovf_evt_s;
    logic [N_REQ-1:0]  nonzero_s;
    logic [N_REQ-1:0]  sticky_r;
    logic [N_REQ-1:0]  sticky_nxt_s;
    logic              pending_any_r;
    logic              hs_s;

    logic [0:0]        state_r;
    logic [0:0]        state_nxt_s;
    logic              grant_valid_r;
    logic              grant_valid_nxt_s;
    logic [ID_W-1:0]   grant_id_r;
    logic [ID_W-1:0]   grant_id_nxt_s;
    logic [ID_W-1:0]   last_r;
    logic [ID_W-1:0]   last_nxt_s;

    logic              sel_found_s;
    logic [ID_W-1:0]   sel_id_s;
    int                sel_idx_s;

    // A handshake only exists while an offer is on the port.
    assign hs_s = grant_valid_r & Grant_ready;

    // Per-channel decrement strobe and nonzero flag.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            dec_s[i]     = hs_s && (grant_id_r == ID_W'(i));
            nonzero_s[i] = (cnt_r[i] != CNT_ZERO);
        end
    end

    // Pending counter update: saturate on pulse, cancel on pulse+handshake.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            ovf_evt_s[i] = 1'b0;
            if (IncPulse_in[i] && !dec_s[i]) begin
                if (cnt_r[i] == CNT_MAX) begin
                    ovf_evt_s[i] = 1'b1;
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
                end
            end else if (!IncPulse_in[i] && dec_s[i]) begin
                cnt_nxt_s[i] = cnt_r[i] - CNT_ONE;
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
    end

    // Sticky overflow flags: clear first, so a same-cycle overflow wins.
    always_comb begin
        if (Clear_overflow) begin
            sticky_nxt_s = ovf_evt_s;
        end else begin
            sticky_nxt_s = sticky_r | ovf_evt_s;
        end
    end

    // Round-robin pick: first nonzero channel scanning from last+1.
    always_comb begin
        sel_found_s = 1'b0;
        sel_id_s    = '0;
        sel_idx_s   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            sel_idx_s = (int'(last_r) + k) % N_REQ;
            if (!sel_found_s && nonzero_s[sel_idx_s]) begin
                sel_found_s = 1'b1;
                sel_id_s    = ID_W'(sel_idx_s);
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Offer FSM: IDLE picks a channel, OFFER holds it until accepted.
    always_comb begin
        state_nxt_s       = state_r;
        grant_valid_nxt_s = grant_valid_r;
        grant_id_nxt_s    = grant_id_r;
        last_nxt_s        = last_r;
        case (state_r)
            ST_IDLE: begin
                if (sel_found_s) begin
                    state_nxt_s       = ST_OFFER;
                    grant_valid_nxt_s = 1'b1;
                    grant_id_nxt_s    = sel_id_s;
                end else begin
                    state_nxt_s       = ST_IDLE;
                    grant_valid_nxt_s = 1'b0;
                end
            end
            ST_OFFER: begin
                if (hs_s) begin
                    state_nxt_s       = ST_IDLE;
                    grant_valid_nxt_s = 1'b0;
                    last_nxt_s        = grant_id_r;
                end else begin
                    state_nxt_s       = ST_OFFER;
                    grant_valid_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s       = ST_IDLE;
                grant_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Counter, sticky and pending-summary registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
            sticky_r      <= '0;
            pending_any_r <= 1'b0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            sticky_r      <= sticky_nxt_s;
            pending_any_r <= |nonzero_s;
        end
    end

    // FSM state and registered grant outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r       <= ST_IDLE;
            grant_valid_r <= 1'b0;
            grant_id_r    <= '0;
            last_r        <= LAST_RST;
        end else begin
            state_r       <= state_nxt_s;
            grant_valid_r <= grant_valid_nxt_s;
            grant_id_r    <= grant_id_nxt_s;
            last_r        <= last_nxt_s;
        end
    end

    assign Grant_valid     = grant_valid_r;
    assign Grant_id        = grant_id_r;
    assign Overflow_sticky = sticky_r;
    assign Pending_any     = pending_any_r;

endmodule
